op_sequencer: RTL and testbench

Command-driven sequencer between the Wishbone configuration path and the FHE datapath (encrypt, decrypt, homomorphic add, homomorphic multiply). It accepts operation descriptors into a small command FIFO, walks each operation row by row, and drives the two SRAM operand read ports in step with the datapath enable. It also issues the result write-back and signals completion. Commands are queued, so software can post the next operation while the current one runs.

---
 rtl/fhe_pkg.sv | 48 ++++
 rtl/cmd_fifo.sv | 50 +++++
 rtl/op_sequencer.sv | 166 ++++++++++++++++
 tb/tb_op_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fhe_pkg.sv
// Shared types for the FHE sequencer: opcodes, sequencer states, command descriptor
// and the per-row operand address rule.
package fhe_pkg;

  // Descriptor address fields are sized here; op_sequencer's ADDR_WIDTH must match.
  localparam int unsigned AddrWidth = 10;

  localparam logic [1:0] OPCODE_ENCRYPT = 2'b00;
  localparam logic [1:0] OPCODE_DECRYPT = 2'b01;
  localparam logic [1:0] OPCODE_ADD     = 2'b10;
  localparam logic [1:0] OPCODE_MULT    = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StWrite
  } seq_state_e;

  typedef struct packed {
    logic [1:0]           opcode;
    logic [AddrWidth-1:0] op1_addr;
    logic [AddrWidth-1:0] op2_addr;
    logic [AddrWidth-1:0] out_addr;
  } cmd_desc_t;

  typedef struct packed {
    logic [AddrWidth-1:0] op1;
    logic [AddrWidth-1:0] op2;
  } radr_t;

  // Operand read addresses for row k of pass `pass`; sums wrap at 2^AddrWidth.
  function automatic radr_t calc_radr(cmd_desc_t d, logic [AddrWidth-1:0] k, logic pass);
    radr_t a;
    a.op1 = d.op1_addr + k;
    a.op2 = d.op2_addr + k;
    case (d.opcode)
      OPCODE_ENCRYPT: a.op1 = d.op1_addr;  // plaintext scalar stays put
      OPCODE_MULT: begin
        a.op1 = (pass ? d.op2_addr : d.op1_addr) + k;
        a.op2 = d.op2_addr;
      end
      default: ;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO for command descriptors with full/empty flags and a synchronous clear.
module cmd_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1;

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [IdxW:0]      wr_ptr_q, rd_ptr_q;
  logic [Width-1:0]   mem_q [Depth];
  logic               do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[IdxW] != rd_ptr_q[IdxW]) &&
                   (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]);
  assign do_push = push_i && !full_o && !clr_i;
  assign do_pop  = pop_i && !empty_o && !clr_i;
  assign rdata_o = mem_q[rd_ptr_q[IdxW-1:0]];

  // Pointer update; clear wins over push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[IdxW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/op_sequencer.sv
// Command-driven sequencer: queues operation descriptors, walks each one row by row
// driving both SRAM operand read ports, then issues the result write-back and done.
module op_sequencer
  import fhe_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = AddrWidth,
  parameter int unsigned DIMENSION  = 10,
  parameter int unsigned DIM_WIDTH  = 4,
  parameter int unsigned CMD_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [1:0]            cmd_opcode_i,
  input  logic [ADDR_WIDTH-1:0] cmd_op1_addr_i,
  input  logic [ADDR_WIDTH-1:0] cmd_op2_addr_i,
  input  logic [ADDR_WIDTH-1:0] cmd_out_addr_i,
  input  logic                  flush_i,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] op1_radr_o,
  output logic [ADDR_WIDTH-1:0] op2_radr_o,
  output logic                  dp_en_o,
  output logic [DIM_WIDTH-1:0]  row_o,
  output logic                  op_select_o,
  output logic [1:0]            opcode_out_o,
  output logic                  out_wen_o,
  output logic [ADDR_WIDTH-1:0] out_wadr_o,
  output logic                  done_o,
  output logic                  busy_o
);

  localparam logic [DIM_WIDTH-1:0] LastRow = DIM_WIDTH'(DIMENSION);

  seq_state_e           state_q;
  cmd_desc_t            desc_q, cmd_in, head;
  logic [DIM_WIDTH-1:0] k_q, k_d, row_q;
  logic                 pass_q, pass_d;
  radr_t                radr_d;
  logic                 fifo_full, fifo_empty, pop;
  logic                 last_row, last_read, is_add, wb_wen;
  logic [AddrWidth-1:0] wb_adr, op1_radr_q, op2_radr_q, out_wadr_q;
  logic                 rd_en_q, dp_en_q, op_select_q, out_wen_q, done_q;
  logic [1:0]           opcode_q;

  assign cmd_in = '{opcode: cmd_opcode_i, op1_addr: cmd_op1_addr_i,
                    op2_addr: cmd_op2_addr_i, out_addr: cmd_out_addr_i};
  assign pop    = (state_q == StIdle) && !fifo_empty && !flush_i;

  cmd_fifo #(
    .Depth(CMD_DEPTH),
    .Width($bits(cmd_desc_t))
  ) u_cmd_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (flush_i),
    .push_i (cmd_valid_i),
    .pop_i  (pop),
    .wdata_i(cmd_in),
    .rdata_o(head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // Next read position (row within pass, pass bit) and its operand addresses.
  always_comb begin
    last_row  = (k_q == LastRow);
    last_read = last_row && (pass_q || desc_q.opcode != OPCODE_MULT);
    k_d       = '0;
    pass_d    = 1'b0;
    radr_d    = '0;
    if (state_q == StIdle) begin
      radr_d = calc_radr(head, '0, 1'b0);
    end else if (last_row) begin
      pass_d = 1'b1;
      radr_d = calc_radr(desc_q, '0, 1'b1);
    end else begin
      k_d    = k_q + 1'b1;
      pass_d = pass_q;
      radr_d = calc_radr(desc_q, AddrWidth'(k_d), pass_q);
    end
  end

  // ADD writes one result per datapath beat; the others write once in WRITE.
  always_comb begin
    is_add = (desc_q.opcode == OPCODE_ADD);
    wb_wen = is_add ? dp_en_q : (state_q == StDrain);
    wb_adr = is_add ? desc_q.out_addr + AddrWidth'(row_q) : desc_q.out_addr;
  end

  // Sequencer FSM with registered read, datapath and write-back outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      desc_q      <= '0;
      k_q         <= '0;
      pass_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      op1_radr_q  <= '0;
      op2_radr_q  <= '0;
      dp_en_q     <= 1'b0;
      row_q       <= '0;
      op_select_q <= 1'b0;
      opcode_q    <= '0;
      out_wen_q   <= 1'b0;
      out_wadr_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      dp_en_q     <= rd_en_q;
      row_q       <= k_q;
      op_select_q <= pass_q;
      out_wen_q   <= wb_wen;
      if (wb_wen) out_wadr_q <= wb_adr;
      done_q      <= (state_q == StDrain);
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            state_q    <= StIssue;
            desc_q     <= head;
            opcode_q   <= head.opcode;
            k_q        <= k_d;
            pass_q     <= pass_d;
            rd_en_q    <= 1'b1;
            op1_radr_q <= radr_d.op1;
            op2_radr_q <= radr_d.op2;
          end
        end
        StIssue: begin
          if (last_read) begin
            state_q <= StDrain;
            rd_en_q <= 1'b0;
          end else begin
            k_q        <= k_d;
            pass_q     <= pass_d;
            op1_radr_q <= radr_d.op1;
            op2_radr_q <= radr_d.op2;
          end
        end
        StDrain: state_q <= StWrite;
        StWrite: state_q <= StIdle;
      endcase
      // Abort squashes everything still in flight, including the pending done.
      if (flush_i) begin
        state_q   <= StIdle;
        rd_en_q   <= 1'b0;
        dp_en_q   <= 1'b0;
        out_wen_q <= 1'b0;
        done_q    <= 1'b0;
      end
    end
  end

  assign cmd_ready_o  = !fifo_full;
  assign busy_o       = (state_q != StIdle) || !fifo_empty;
  assign rd_en_o      = rd_en_q;
  assign op1_radr_o   = op1_radr_q;
  assign op2_radr_o   = op2_radr_q;
  assign dp_en_o      = dp_en_q;
  assign row_o        = row_q;
  assign op_select_o  = op_select_q;
  assign opcode_out_o = opcode_q;
  assign out_wen_o    = out_wen_q;
  assign out_wadr_o   = out_wadr_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_op_sequencer.sv
// Self-checking bench for op_sequencer: directed table, back-pressure, random traffic
// against a reference model, flush and mid-operation reset.
module tb_op_sequencer;

  localparam int D   = 10;
  localparam int AWM = 1024;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_opcode = '0;
  logic [9:0] cmd_op1_addr = '0, cmd_op2_addr = '0, cmd_out_addr = '0;
  logic       flush = 1'b0;
  logic       rd_en, dp_en, op_select, out_wen, done, busy;
  logic [9:0] op1_radr, op2_radr, out_wadr;
  logic [3:0] row;
  logic [1:0] opcode_out;

  op_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_opcode_i  (cmd_opcode),
    .cmd_op1_addr_i(cmd_op1_addr),
    .cmd_op2_addr_i(cmd_op2_addr),
    .cmd_out_addr_i(cmd_out_addr),
    .flush_i       (flush),
    .rd_en_o       (rd_en),
    .op1_radr_o    (op1_radr),
    .op2_radr_o    (op2_radr),
    .dp_en_o       (dp_en),
    .row_o         (row),
    .op_select_o   (op_select),
    .opcode_out_o  (opcode_out),
    .out_wen_o     (out_wen),
    .out_wadr_o    (out_wadr),
    .done_o        (done),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err = 0;

  typedef struct {int cyc; int a1; int a2;} rd_ev_t;
  typedef struct {int cyc; int row; int sel;} dp_ev_t;
  typedef struct {int cyc; int adr;} wr_ev_t;

  rd_ev_t rd_log[$], exp_rd[$];
  dp_ev_t dp_log[$], exp_dp[$];
  wr_ev_t wr_log[$], exp_wr[$];
  int     done_log[$];
  int     exp_ncmd = 0;

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    rd_ev_t r;
    dp_ev_t p;
    wr_ev_t w;
    if (rd_en) begin r.cyc = cyc; r.a1 = int'(op1_radr); r.a2 = int'(op2_radr); rd_log.push_back(r); end
    if (dp_en) begin p.cyc = cyc; p.row = int'(row); p.sel = int'(op_select); dp_log.push_back(p); end
    if (out_wen) begin w.cyc = cyc; w.adr = int'(out_wadr); wr_log.push_back(w); end
    if (done) done_log.push_back(cyc);
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: what one command should produce, straight from the address rules.
  task automatic model_cmd(input int op, input int a1, input int a2, input int ao);
    int n;
    rd_ev_t r;
    dp_ev_t p;
    wr_ev_t w;
    n = (op == 3) ? 2 * (D + 1) : D + 1;
    for (int i = 0; i < n; i++) begin
      int k;
      int ps;
      k = i % (D + 1);
      ps = i / (D + 1);
      r.cyc = 0;
      case (op)
        0: begin r.a1 = a1; r.a2 = a2 + k; end
        3: begin r.a1 = (ps != 0 ? a2 : a1) + k; r.a2 = a2; end
        default: begin r.a1 = a1 + k; r.a2 = a2 + k; end
      endcase
      r.a1 = r.a1 % AWM;
      r.a2 = r.a2 % AWM;
      exp_rd.push_back(r);
      p.cyc = 0; p.row = k; p.sel = ps;
      exp_dp.push_back(p);
    end
    w.cyc = 0;
    if (op == 2) begin
      for (int k = 0; k <= D; k++) begin w.adr = (ao + k) % AWM; exp_wr.push_back(w); end
    end else begin
      w.adr = ao;
      exp_wr.push_back(w);
    end
    exp_ncmd++;
  endtask

  task automatic clear_logs();
    rd_log.delete(); dp_log.delete(); wr_log.delete(); done_log.delete();
    exp_rd.delete(); exp_dp.delete(); exp_wr.delete();
    exp_ncmd = 0;
  endtask

  task automatic compare_logs(input string tag);
    check({tag, " rd count"}, rd_log.size(), exp_rd.size());
    for (int i = 0; i < rd_log.size() && i < exp_rd.size(); i++) begin
      check($sformatf("%s rd%0d op1", tag, i), rd_log[i].a1, exp_rd[i].a1);
      check($sformatf("%s rd%0d op2", tag, i), rd_log[i].a2, exp_rd[i].a2);
    end
    check({tag, " dp count"}, dp_log.size(), exp_dp.size());
    for (int i = 0; i < dp_log.size() && i < exp_dp.size(); i++) begin
      check($sformatf("%s dp%0d row", tag, i), dp_log[i].row, exp_dp[i].row);
      check($sformatf("%s dp%0d sel", tag, i), dp_log[i].sel, exp_dp[i].sel);
      if (i < rd_log.size())
        check($sformatf("%s dp%0d lag", tag, i), dp_log[i].cyc - rd_log[i].cyc, 1);
    end
    check({tag, " wr count"}, wr_log.size(), exp_wr.size());
    for (int i = 0; i < wr_log.size() && i < exp_wr.size(); i++)
      check($sformatf("%s wr%0d adr", tag, i), wr_log[i].adr, exp_wr[i].adr);
    check({tag, " done count"}, done_log.size(), exp_ncmd);
  endtask

  // Offer a command (entered at posedge+1) until accepted; returns the accept cycle.
  task automatic push(input int op, input int a1, input int a2, input int ao, output int t);
    logic [31:0] v1, v2, v3, vo;
    v1 = op; v2 = a1; v3 = a2; vo = ao;
    cmd_valid = 1'b1;
    cmd_opcode = v1[1:0];
    cmd_op1_addr = v2[9:0];
    cmd_op2_addr = v3[9:0];
    cmd_out_addr = vo[9:0];
    t = -1;
    for (int i = 0; i < 300 && t < 0; i++) begin
      @(negedge clk);
      if (cmd_ready) t = cyc;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    check("push accepted", int'(t >= 0), 1);
    if (t >= 0) model_cmd(op, a1, a2, ao);
  endtask

  task automatic wait_done(input int n, input int budget);
    for (int i = 0; i < budget && done_log.size() < n; i++) @(negedge clk);
    check("done within budget", int'(done_log.size() >= n), 1);
    @(posedge clk); #1;
  endtask

  // Stop at the negedge where row `r` of an ENCRYPT based at op2 `b` is being read.
  task automatic wait_row(input int b, input int r, output int ok);
    ok = 0;
    for (int i = 0; i < 80 && ok == 0; i++) begin
      @(negedge clk);
      if (rd_en && int'(op2_radr) == b + r) ok = 1;
    end
    check("reached target row", ok, 1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " cmd_ready"}, int'(cmd_ready), 1);
    check({tag, " rd_en"}, int'(rd_en), 0);
    check({tag, " dp_en"}, int'(dp_en), 0);
    check({tag, " out_wen"}, int'(out_wen), 0);
    check({tag, " done"}, int'(done), 0);
    check({tag, " busy"}, int'(busy), 0);
    check({tag, " row"}, int'(row), 0);
    check({tag, " op_select"}, int'(op_select), 0);
    check({tag, " opcode_out"}, int'(opcode_out), 0);
    check({tag, " op1_radr"}, int'(op1_radr), 0);
    check({tag, " op2_radr"}, int'(op2_radr), 0);
    check({tag, " out_wadr"}, int'(out_wadr), 0);
  endtask

  typedef struct {
    int op, a1, a2, ao;
    int nrd, op1_first, op1_last, op2_first, op2_last;
    int nwr, w_first, w_last, lat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int t, t5, f, ok, rc;

    vecs[0] = '{0, 'h010, 'h100, 'h200, 11, 'h010, 'h010, 'h100, 'h10A, 1,  'h200, 'h200, 14};
    vecs[1] = '{2, 'h020, 'h040, 'h300, 11, 'h020, 'h02A, 'h040, 'h04A, 11, 'h300, 'h30A, 14};
    vecs[2] = '{3, 'h050, 'h070, 'h3E0, 22, 'h050, 'h07A, 'h070, 'h070, 1,  'h3E0, 'h3E0, 25};
    vecs[3] = '{0, 'h001, 'h3FC, 'h111, 11, 'h001, 'h001, 'h3FC, 'h006, 1,  'h111, 'h111, 14};
    vecs[4] = '{1, 'h3FA, 'h0F0, 'h005, 11, 'h3FA, 'h004, 'h0F0, 'h0FA, 1,  'h005, 'h005, 14};

    #1 check_idle("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table: one command at a time from idle.
    for (int v = 0; v < 5; v++) begin
      string tg;
      tg = $sformatf("vec%0d", v);
      clear_logs();
      push(vecs[v].op, vecs[v].a1, vecs[v].a2, vecs[v].ao, t);
      wait_done(1, 60);
      repeat (3) @(posedge clk);
      #1;
      check({tg, " nrd"}, rd_log.size(), vecs[v].nrd);
      check({tg, " nwr"}, wr_log.size(), vecs[v].nwr);
      if (rd_log.size() > 0) begin
        check({tg, " first rd lat"}, rd_log[0].cyc - t, 2);
        check({tg, " op1 first"}, rd_log[0].a1, vecs[v].op1_first);
        check({tg, " op1 last"}, rd_log[rd_log.size()-1].a1, vecs[v].op1_last);
        check({tg, " op2 first"}, rd_log[0].a2, vecs[v].op2_first);
        check({tg, " op2 last"}, rd_log[rd_log.size()-1].a2, vecs[v].op2_last);
      end
      if (dp_log.size() > 0) check({tg, " first dp lat"}, dp_log[0].cyc - t, 3);
      if (wr_log.size() > 0 && done_log.size() > 0) begin
        check({tg, " w first"}, wr_log[0].adr, vecs[v].w_first);
        check({tg, " w last"}, wr_log[wr_log.size()-1].adr, vecs[v].w_last);
        check({tg, " done with last write"}, done_log[0], wr_log[wr_log.size()-1].cyc);
        check({tg, " done lat"}, done_log[0] - t, vecs[v].lat);
      end
      check({tg, " opcode_out"}, int'(opcode_out), vecs[v].op);
      compare_logs(tg);
    end

    // Back-pressure: four queued behind a running ENCRYPT fill the FIFO.
    clear_logs();
    push(0, 'h011, 'h120, 'h210, t);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) push(0, 'h040 + i, 'h140 + 16 * i, 'h250 + i, rc);
    check("bp ready low when full", int'(cmd_ready), 0);
    push(0, 'h0AA, 'h1F0, 'h2AA, t5);
    if (done_log.size() > 0) check("bp 5th accept after pop", t5 - done_log[0], 2);
    wait_done(6, 200);
    repeat (3) @(posedge clk);
    #1;
    compare_logs("bp");
    // Each command costs ISSUE(11) + DRAIN + WRITE + IDLE.
    for (int i = 1; i < done_log.size(); i++)
      check($sformatf("bp done spacing %0d", i), done_log[i] - done_log[i-1], 14);

    // Random traffic against the reference model.
    clear_logs();
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 16)) @(posedge clk);
      #1;
      push(int'($urandom_range(0, 3)), int'($urandom_range(0, 1023)),
           int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), rc);
    end
    ok = 0;
    for (int i = 0; i < 3000 && ok == 0; i++) begin
      @(negedge clk);
      if (!busy) ok = 1;
    end
    check("rand drains", ok, 1);
    repeat (3) @(posedge clk);
    #1;
    compare_logs("rand");

    // Flush at ISSUE row 5 with two commands queued.
    clear_logs();
    push(0, 'h000, 'h180, 'h222, rc);
    push(1, 'h010, 'h020, 'h030, rc);
    push(2, 'h040, 'h050, 'h060, rc);
    wait_row('h180, 5, ok);
    flush = 1'b1;
    f = cyc;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush rd_en next", int'(rd_en), 0);
    check("flush dp_en next", int'(dp_en), 0);
    @(negedge clk);
    check("flush busy +2", int'(busy), 0);
    repeat (20) @(negedge clk);
    rc = 0;
    foreach (rd_log[i]) if (rd_log[i].cyc > f) rc++;
    foreach (dp_log[i]) if (dp_log[i].cyc > f) rc++;
    check("flush no later beats", rc, 0);
    check("flush no writes", wr_log.size(), 0);
    check("flush no done", done_log.size(), 0);
    @(posedge clk); #1;

    // Asynchronous reset at row 5.
    clear_logs();
    push(0, 'h030, 'h1C0, 'h240, rc);
    wait_row('h1C0, 5, ok);
    rst_n = 1'b0;
    f = cyc;
    #1 check_idle("mid reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    rc = 0;
    foreach (rd_log[i]) if (rd_log[i].cyc > f) rc++;
    check("reset no later reads", rc, 0);
    check("reset no writes", wr_log.size(), 0);
    check("reset no done", done_log.size(), 0);
    check_idle("after release");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
